// File: rtl/dds_spi_responder.sv
// 3-wire serial write responder: shadow freq/phase/amp registers, committed on io_update rising edge.
// Commit latency SYNC_STAGES+2 clk_in cycles; no backpressure. Readback port under DDS_SPI_READBACK_EN.
module dds_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        sclk_in,
  input  logic        csb_in,
  input  logic        sdio_in,
  input  logic        io_update_in,
`ifdef DDS_SPI_READBACK_EN
  output logic        sdio_out,
  output logic        sdio_oe,
`endif
  output logic [47:0] freq_out,
  output logic [13:0] phase_out,
  output logic [9:0]  amp_out,
  output logic        freq_update,
  output logic        phase_update,
  output logic        amp_update,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    ST_WAIT_CSB,
    ST_IDLE,
    ST_INSTR,
    ST_DATA,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, sdio_sync, io_sync;
  logic sclk_hist, csb_hist, io_hist;
  logic sclk_s, csb_s, sdio_s, io_s;
  logic sclk_rise, csb_fall, csb_rise, io_rise;

  // Reset the csb synchronizer low so ST_WAIT_CSB only trusts a real idle level.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sclk_sync <= '0;
      csb_sync  <= '0;
      sdio_sync <= '0;
      io_sync   <= '0;
      sclk_hist <= 1'b0;
      csb_hist  <= 1'b0;
      io_hist   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_in};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio_in};
      io_sync   <= {io_sync[SYNC_STAGES-2:0], io_update_in};
      sclk_hist <= sclk_s;
      csb_hist  <= csb_s;
      io_hist   <= io_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign io_s      = io_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign csb_fall  = ~csb_s & csb_hist;
  assign csb_rise  = csb_s & ~csb_hist;
  assign io_rise   = io_s & ~io_hist;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [14:0] shift_q;
  logic        rw_q;
  logic        stream_q;
  logic [1:0]  bytes_left;
  logic [12:0] addr_q;
  logic [15:0] instr_word;
  logic        byte_last;
  logic        wr_en;

  assign instr_word = {shift_q, sdio_s};
  assign byte_last  = (bit_cnt[2:0] == 3'd7);
  assign wr_en      = (state == ST_DATA) && sclk_rise && !csb_rise && byte_last && !rw_q;

  logic [47:0] freq_sh, freq_nxt;
  logic [13:0] phase_sh, phase_nxt;
  logic [9:0]  amp_sh, amp_nxt;
  logic        freq_dirty, phase_dirty, amp_dirty;
  logic        freq_dirty_nxt, phase_dirty_nxt, amp_dirty_nxt;
  logic [1:0]  commit_pipe;
  logic        commit;

  // Next-state shadow view lets a byte landing on the commit cycle join that commit.
  always_comb begin
    freq_nxt        = freq_sh;
    phase_nxt       = phase_sh;
    amp_nxt         = amp_sh;
    freq_dirty_nxt  = freq_dirty;
    phase_dirty_nxt = phase_dirty;
    amp_dirty_nxt   = amp_dirty;
    if (wr_en) begin
      case (addr_q)
        13'h01AB: begin freq_nxt[47:40] = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01AA: begin freq_nxt[39:32] = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01A9: begin freq_nxt[31:24] = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01A8: begin freq_nxt[23:16] = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01A7: begin freq_nxt[15:8]  = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01A6: begin freq_nxt[7:0]   = instr_word[7:0]; freq_dirty_nxt = 1'b1; end
        13'h01AD: begin phase_nxt[13:8] = instr_word[5:0]; phase_dirty_nxt = 1'b1; end
        13'h01AC: begin phase_nxt[7:0]  = instr_word[7:0]; phase_dirty_nxt = 1'b1; end
        13'h040C: begin amp_nxt[9:8]    = instr_word[1:0]; amp_dirty_nxt = 1'b1; end
        13'h040B: begin amp_nxt[7:0]    = instr_word[7:0]; amp_dirty_nxt = 1'b1; end
        default: ;
      endcase
    end
  end

  // Two pipeline stages after edge detection fix the commit at SYNC_STAGES+2 cycles.
  assign commit = commit_pipe[1];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      commit_pipe  <= '0;
      freq_sh      <= '0;
      phase_sh     <= '0;
      amp_sh       <= '0;
      freq_dirty   <= 1'b0;
      phase_dirty  <= 1'b0;
      amp_dirty    <= 1'b0;
      freq_out     <= '0;
      phase_out    <= '0;
      amp_out      <= '0;
      freq_update  <= 1'b0;
      phase_update <= 1'b0;
      amp_update   <= 1'b0;
    end else begin
      commit_pipe  <= {commit_pipe[0], io_rise};
      freq_sh      <= freq_nxt;
      phase_sh     <= phase_nxt;
      amp_sh       <= amp_nxt;
      freq_dirty   <= freq_dirty_nxt & ~commit;
      phase_dirty  <= phase_dirty_nxt & ~commit;
      amp_dirty    <= amp_dirty_nxt & ~commit;
      freq_update  <= commit & freq_dirty_nxt;
      phase_update <= commit & phase_dirty_nxt;
      amp_update   <= commit & amp_dirty_nxt;
      if (commit && freq_dirty_nxt)  freq_out  <= freq_nxt;
      if (commit && phase_dirty_nxt) phase_out <= phase_nxt;
      if (commit && amp_dirty_nxt)   amp_out   <= amp_nxt;
    end
  end

`ifdef DDS_SPI_READBACK_EN
  logic sclk_fall;
  logic [7:0] rd_byte;

  assign sclk_fall = ~sclk_s & sclk_hist;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      13'h01AB: rd_byte = freq_sh[47:40];
      13'h01AA: rd_byte = freq_sh[39:32];
      13'h01A9: rd_byte = freq_sh[31:24];
      13'h01A8: rd_byte = freq_sh[23:16];
      13'h01A7: rd_byte = freq_sh[15:8];
      13'h01A6: rd_byte = freq_sh[7:0];
      13'h01AD: rd_byte = {2'b00, phase_sh[13:8]};
      13'h01AC: rd_byte = phase_sh[7:0];
      13'h040C: rd_byte = {6'b000000, amp_sh[9:8]};
      13'h040B: rd_byte = amp_sh[7:0];
      default:  rd_byte = 8'h00;
    endcase
  end
`endif

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state      <= ST_WAIT_CSB;
      bit_cnt    <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      stream_q   <= 1'b0;
      bytes_left <= '0;
      addr_q     <= '0;
      frame_err  <= 1'b0;
`ifdef DDS_SPI_READBACK_EN
      sdio_out   <= 1'b0;
      sdio_oe    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (sclk_rise) shift_q <= instr_word[14:0];
      if (csb_rise && (state == ST_INSTR || state == ST_DATA || state == ST_DONE)) begin
        frame_err <= (state == ST_INSTR) ||
                     (state == ST_DATA && (bit_cnt[2:0] != 3'd0 || !stream_q));
        state     <= ST_IDLE;
`ifdef DDS_SPI_READBACK_EN
        sdio_oe   <= 1'b0;
`endif
      end else begin
        case (state)
          ST_WAIT_CSB: if (csb_s) state <= ST_IDLE;
          ST_IDLE: begin
            if (csb_fall) begin
              bit_cnt <= '0;
              state   <= ST_INSTR;
            end
          end
          ST_INSTR: begin
            if (sclk_rise) begin
              if (bit_cnt == 4'd15) begin
                rw_q       <= instr_word[15];
                stream_q   <= &instr_word[14:13];
                bytes_left <= instr_word[14:13];
                addr_q     <= instr_word[12:0];
                bit_cnt    <= '0;
                state      <= ST_DATA;
`ifdef DDS_SPI_READBACK_EN
                sdio_oe    <= instr_word[15];
`endif
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              bit_cnt <= {1'b0, bit_cnt[2:0] + 3'd1};
              if (byte_last) begin
                addr_q <= addr_q - 13'd1;
                if (!stream_q) begin
                  if (bytes_left == 2'd0) begin
                    state <= ST_DONE;
`ifdef DDS_SPI_READBACK_EN
                    sdio_oe <= 1'b0;
`endif
                  end else begin
                    bytes_left <= bytes_left - 2'd1;
                  end
                end
              end
            end
`ifdef DDS_SPI_READBACK_EN
            if (sclk_fall && rw_q) sdio_out <= rd_byte[~bit_cnt[2:0]];
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_spi_responder.sv
// Bench for dds_spi_responder: reference model + expected-commit queue checked on update pulses.
module tb_dds_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 60;

  logic clk_in = 1'b0;
  logic reset_in, sclk_in, csb_in, sdio_in, io_update_in;
  logic [47:0] freq_out;
  logic [13:0] phase_out;
  logic [9:0]  amp_out;
  logic freq_update, phase_update, amp_update, frame_err;
`ifdef DDS_SPI_READBACK_EN
  logic sdio_out, sdio_oe;
`endif

  dds_spi_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .sclk_in(sclk_in), .csb_in(csb_in),
    .sdio_in(sdio_in), .io_update_in(io_update_in),
`ifdef DDS_SPI_READBACK_EN
    .sdio_out(sdio_out), .sdio_oe(sdio_oe),
`endif
    .freq_out(freq_out), .phase_out(phase_out), .amp_out(amp_out),
    .freq_update(freq_update), .phase_update(phase_update), .amp_update(amp_update),
    .frame_err(frame_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_seen = 0;
  int exp_err = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  mask;
    logic [47:0] f;
    logic [13:0] p;
    logic [9:0]  a;
  } exp_t;
  exp_t sb_q[$];

  logic [47:0] m_fsh, m_f;
  logic [13:0] m_psh, m_p;
  logic [9:0]  m_ash, m_a;
  logic [2:0]  m_dirty;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;
  always @(negedge clk_in) if (frame_err) err_seen++;

  always @(negedge clk_in) begin
    if (freq_update || phase_update || amp_update) begin
      if (sb_q.size() == 0) begin
        check("unexpected_update", {freq_update, phase_update, amp_update}, 3'b000);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("update_cycle", cyc, e.cyc);
        check("update_mask", {freq_update, phase_update, amp_update}, e.mask);
        check("freq_out", freq_out, e.f);
        check("phase_out", phase_out, e.p);
        check("amp_out", amp_out, e.a);
      end
    end
  end

  task automatic model_reset();
    m_fsh = '0; m_f = '0; m_psh = '0; m_p = '0; m_ash = '0; m_a = '0; m_dirty = '0;
  endtask

  task automatic apply_byte(input logic [12:0] addr, input logic [7:0] b);
    if (addr >= 13'h01A6 && addr <= 13'h01AB) begin
      m_fsh[(addr - 13'h01A6) * 8 +: 8] = b;
      m_dirty[2] = 1'b1;
    end else if (addr == 13'h01AD) begin
      m_psh[13:8] = b[5:0]; m_dirty[1] = 1'b1;
    end else if (addr == 13'h01AC) begin
      m_psh[7:0] = b; m_dirty[1] = 1'b1;
    end else if (addr == 13'h040C) begin
      m_ash[9:8] = b[1:0]; m_dirty[0] = 1'b1;
    end else if (addr == 13'h040B) begin
      m_ash[7:0] = b; m_dirty[0] = 1'b1;
    end
  endtask

  task automatic spi_bit(input logic b);
    sclk_in = 1'b0; sdio_in = b; #HALF;
    sclk_in = 1'b1; #HALF;
  endtask

  task automatic spi_frame(input logic [15:0] instr, input int ninstr,
                           input logic [63:0] data, input int ndata,
                           output logic [63:0] rd_cap, output int oe_low);
    int nbytes, cnt;
    logic [12:0] a;
    rd_cap = '0;
    oe_low = 0;
    csb_in = 1'b0; #HALF;
    for (int i = 0; i < ninstr; i++) spi_bit(instr[15-i]);
    for (int i = 0; i < ndata; i++) begin
      sclk_in = 1'b0; sdio_in = data[ndata-1-i]; #HALF;
`ifdef DDS_SPI_READBACK_EN
      rd_cap = {rd_cap[62:0], sdio_out};
      if (!sdio_oe) oe_low++;
`endif
      sclk_in = 1'b1; #HALF;
    end
    #HALF; csb_in = 1'b1; #(8*HALF);
    if (ninstr < 16) begin
      exp_err++;
    end else begin
      nbytes = ndata / 8;
      cnt = (instr[14:13] == 2'b11) ? nbytes
          : ((nbytes < int'(instr[14:13]) + 1) ? nbytes : int'(instr[14:13]) + 1);
      a = instr[12:0];
      for (int k = 0; k < cnt; k++) begin
        if (!instr[15]) apply_byte(a, data[ndata-1-8*k -: 8]);
        a = a - 13'd1;
      end
      if (instr[14:13] == 2'b11) begin
        if (ndata % 8 != 0) exp_err++;
      end else if (ndata < 8 * (int'(instr[14:13]) + 1)) begin
        exp_err++;
      end
    end
  endtask

  task automatic io_update();
    exp_t e;
    @(negedge clk_in);
    if (m_dirty[2]) m_f = m_fsh;
    if (m_dirty[1]) m_p = m_psh;
    if (m_dirty[0]) m_a = m_ash;
    if (m_dirty != 3'b000) begin
      e.cyc = cyc + 1 + SYNC + 2;
      e.mask = m_dirty; e.f = m_f; e.p = m_p; e.a = m_a;
      sb_q.push_back(e);
    end
    m_dirty = '0;
    io_update_in = 1'b1;
    repeat (6) @(negedge clk_in);
    io_update_in = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_freq"}, freq_out, m_f);
    check({tag, "_phase"}, phase_out, m_p);
    check({tag, "_amp"}, amp_out, m_a);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
    check({tag, "_frame_err_cnt"}, err_seen, exp_err);
  endtask

  logic [63:0] rd;
  int oe_low;

  initial begin
    reset_in = 1'b1; sclk_in = 1'b1; csb_in = 1'b1; sdio_in = 1'b0; io_update_in = 1'b0;
    model_reset();
    repeat (5) @(negedge clk_in);
    check_outputs("reset");
    check("reset_pulses", {freq_update, phase_update, amp_update, frame_err}, 4'b0000);
    reset_in = 1'b0;
    repeat (10) @(negedge clk_in);

    // Streaming frequency write
    spi_frame(16'h61AB, 16, 64'h123456789ABC, 48, rd, oe_low);
    io_update();
    check_outputs("freq");

    // Phase and amplitude committed together
    spi_frame(16'h21AD, 16, 64'h3FFF, 16, rd, oe_low);
    spi_frame(16'h240C, 16, 64'h03FF, 16, rd, oe_low);
    io_update();
    check_outputs("phase_amp");

    // Malformed frames: partial streaming byte, short fixed count, truncated instruction
    spi_frame(16'h61AB, 16, 64'hFEDCB, 20, rd, oe_low);
    check("err_partial", err_seen, exp_err);
    spi_frame(16'h21AD, 16, 64'h15, 8, rd, oe_low);
    check("err_short", err_seen, exp_err);
    spi_frame(16'h21AD, 8, 64'h0, 0, rd, oe_low);
    check("err_instr", err_seen, exp_err);
    io_update();
    check_outputs("partial");

    // Unmapped write and a read frame leave everything untouched
    spi_frame(16'h2100, 16, 64'hAAAA, 16, rd, oe_low);
    spi_frame(16'hA1AD, 16, 64'hFFFF, 16, rd, oe_low);
    io_update();
    check_outputs("unmapped");

`ifdef DDS_SPI_READBACK_EN
    spi_frame(16'h21AD, 16, 64'h2A55, 16, rd, oe_low);
    spi_frame(16'hA1AD, 16, 64'h0, 16, rd, oe_low);
    check("readback_data", rd[15:0], 16'h2A55);
    check("readback_oe_low", oe_low, 0);
    io_update();
    check_outputs("readback");
`endif

    // Reset in the middle of a frame, csb held low afterwards
    csb_in = 1'b0; #HALF;
    for (int i = 0; i < 8; i++) spi_bit(i[0]);
    @(negedge clk_in); reset_in = 1'b1;
    repeat (3) @(negedge clk_in); reset_in = 1'b0;
    model_reset();
    check_outputs("midreset");
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    #HALF; csb_in = 1'b1; #(8*HALF);
    spi_frame(16'h21AD, 16, 64'h1234, 16, rd, oe_low);
    io_update();
    check_outputs("after_reset");
    check("after_reset_phase", phase_out, 14'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
